// File: rtl/vga_tim_pkg.sv
// Shared types and constants for the VGA timing generator: counter width,
// mode geometry struct and a few standard modes.
package vga_tim_pkg;

  localparam int CNT_W     = 11;
  localparam int MAX_TOTAL = 2048;

  typedef struct packed {
    logic [CNT_W-1:0] h_active;
    logic [CNT_W-1:0] h_fp;
    logic [CNT_W-1:0] h_sync;
    logic [CNT_W-1:0] h_bp;
    logic [CNT_W-1:0] v_active;
    logic [CNT_W-1:0] v_fp;
    logic [CNT_W-1:0] v_sync;
    logic [CNT_W-1:0] v_bp;
    logic             h_pol;
    logic             v_pol;
  } vga_mode_t;

  localparam vga_mode_t MODE_640X480 = '{
    h_active: 11'd640, h_fp: 11'd16, h_sync: 11'd96,  h_bp: 11'd48,
    v_active: 11'd480, v_fp: 11'd10, v_sync: 11'd2,   v_bp: 11'd33,
    h_pol: 1'b0, v_pol: 1'b0};

  localparam vga_mode_t MODE_800X600 = '{
    h_active: 11'd800, h_fp: 11'd40, h_sync: 11'd128, h_bp: 11'd88,
    v_active: 11'd600, v_fp: 11'd1,  v_sync: 11'd4,   v_bp: 11'd23,
    h_pol: 1'b1, v_pol: 1'b1};

  localparam vga_mode_t MODE_1024X768 = '{
    h_active: 11'd1024, h_fp: 11'd24, h_sync: 11'd136, h_bp: 11'd160,
    v_active: 11'd768,  v_fp: 11'd3,  v_sync: 11'd6,   v_bp: 11'd29,
    h_pol: 1'b0, v_pol: 1'b0};

  function automatic int unsigned axis_total(input int unsigned active, input int unsigned fp,
                                             input int unsigned sync, input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_tim.sv
// VGA timing bus: counts plus blank/sync flags, driven by vga_timing_gen.
interface vga_tim;

  logic [vga_tim_pkg::CNT_W-1:0] hcount;
  logic [vga_tim_pkg::CNT_W-1:0] vcount;
  logic                          hsync;
  logic                          vsync;
  logic                          hblnk;
  logic                          vblnk;

  modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk);
  modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk);

endinterface

// File: rtl/vga_axis_cnt.sv
// One timing axis: wrapping counter with registered blank/sync decode.
// Flags are decoded from the next count so they change on the same edge.
module vga_axis_cnt
  import vga_tim_pkg::*;
#(
  parameter int unsigned ACTIVE = 800,
  parameter int unsigned FP     = 40,
  parameter int unsigned SYNC   = 128,
  parameter int unsigned BP     = 88,
  parameter logic        POL    = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             adv,
  output logic [CNT_W-1:0] count,
  output logic             wrap,
  output logic             blnk,
  output logic             sync,
  output logic             blnk_nxt
);

  localparam int unsigned TOTAL = axis_total(ACTIVE, FP, SYNC, BP);

  if (ACTIVE == 0 || SYNC == 0) begin : g_bad_zero
    $error("vga_axis_cnt: ACTIVE and SYNC must be non-zero");
  end
  if (TOTAL > MAX_TOTAL) begin : g_bad_total
    $error("vga_axis_cnt: axis total exceeds counter range");
  end

  localparam logic [CNT_W-1:0] LAST    = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] ACT_END = CNT_W'(ACTIVE);
  localparam logic [CNT_W-1:0] SYNC_LO = CNT_W'(ACTIVE + FP);
  localparam logic [CNT_W-1:0] SYNC_HI = CNT_W'(ACTIVE + FP + SYNC - 1);

  logic [CNT_W-1:0] count_nxt;
  logic             sync_nxt;

  assign wrap = (count == LAST);

  // NOTE: default assignment first so the held path never infers a latch.
  always_comb begin
    count_nxt = count;
    if (adv) count_nxt = wrap ? '0 : count + 1'b1;
  end

  assign blnk_nxt = (count_nxt >= ACT_END);
  assign sync_nxt = ((count_nxt >= SYNC_LO) && (count_nxt <= SYNC_HI)) ? POL : ~POL;

  // NOTE: non-blocking assignments for all registered state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      blnk  <= 1'b0;
      sync  <= ~POL;
    end else begin
      count <= count_nxt;
      blnk  <= blnk_nxt;
      sync  <= sync_nxt;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator driving the vga_tim bus, plus de and
// line/frame strobes. Optional frame counter under VGA_TIM_FRAME_CNT_EN.
module vga_timing_gen
  import vga_tim_pkg::*;
#(
  parameter int unsigned H_ACTIVE   = 800,
  parameter int unsigned H_FP       = 40,
  parameter int unsigned H_SYNC     = 128,
  parameter int unsigned H_BP       = 88,
  parameter int unsigned V_ACTIVE   = 600,
  parameter int unsigned V_FP       = 1,
  parameter int unsigned V_SYNC     = 4,
  parameter int unsigned V_BP       = 23,
  parameter logic        H_SYNC_POL = 1'b1,
  parameter logic        V_SYNC_POL = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  vga_tim.out         tim,
  output logic        de,
  output logic        line_start,
  output logic        frame_start
`ifdef VGA_TIM_FRAME_CNT_EN
  ,
  output logic [15:0] frame_cnt
`endif
);

  logic [CNT_W-1:0] hcount, vcount;
  logic             h_wrap, v_wrap;
  logic             hblnk_nxt, vblnk_nxt;
  logic             hsync, vsync, hblnk, vblnk;
  logic             frame_evt;

  vga_axis_cnt #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .POL(H_SYNC_POL)
  ) u_h_axis (
    .clk(clk), .rst_n(rst_n), .adv(en),
    .count(hcount), .wrap(h_wrap), .blnk(hblnk), .sync(hsync), .blnk_nxt(hblnk_nxt)
  );

  vga_axis_cnt #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .POL(V_SYNC_POL)
  ) u_v_axis (
    .clk(clk), .rst_n(rst_n), .adv(en & h_wrap),
    .count(vcount), .wrap(v_wrap), .blnk(vblnk), .sync(vsync), .blnk_nxt(vblnk_nxt)
  );

  assign tim.hcount = hcount;
  assign tim.vcount = vcount;
  assign tim.hsync  = hsync;
  assign tim.vsync  = vsync;
  assign tim.hblnk  = hblnk;
  assign tim.vblnk  = vblnk;

  // Strobes fire only when the counters actually advance into position 0.
  assign frame_evt = en & h_wrap & v_wrap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      de          <= 1'b1;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
`ifdef VGA_TIM_FRAME_CNT_EN
      frame_cnt   <= '0;
`endif
    end else begin
      de          <= ~(hblnk_nxt | vblnk_nxt);
      line_start  <= en & h_wrap;
      frame_start <= frame_evt;
`ifdef VGA_TIM_FRAME_CNT_EN
      if (frame_evt) frame_cnt <= frame_cnt + 16'd1;
`endif
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: three geometries run in lockstep,
// expected outputs pushed at drive time and compared on the falling edge.
`timescale 1ns/1ps
module tb_vga_timing_gen;
  import vga_tim_pkg::*;

  localparam vga_mode_t MODE_A = MODE_800X600;
  localparam vga_mode_t MODE_B = MODE_640X480;
  localparam vga_mode_t MODE_C = '{
    h_active: 11'd8, h_fp: 11'd0, h_sync: 11'd3, h_bp: 11'd2,
    v_active: 11'd4, v_fp: 11'd1, v_sync: 11'd2, v_bp: 11'd0,
    h_pol: 1'b1, v_pol: 1'b1};

  typedef struct packed {
    logic [10:0] h;
    logic [10:0] v;
    logic        hs, vs, hb, vb, de, ls, fs;
    logic [15:0] fc;
  } exp_t;

  logic clk, rst_n, en;
  logic de_a, ls_a, fs_a, de_b, ls_b, fs_b, de_c, ls_c, fs_c;
  logic [15:0] fc_a, fc_b, fc_c;

  vga_tim tim_a();
  vga_tim tim_b();
  vga_tim tim_c();

  vga_timing_gen #(
    .H_ACTIVE(MODE_A.h_active), .H_FP(MODE_A.h_fp), .H_SYNC(MODE_A.h_sync), .H_BP(MODE_A.h_bp),
    .V_ACTIVE(MODE_A.v_active), .V_FP(MODE_A.v_fp), .V_SYNC(MODE_A.v_sync), .V_BP(MODE_A.v_bp),
    .H_SYNC_POL(MODE_A.h_pol), .V_SYNC_POL(MODE_A.v_pol)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .tim(tim_a),
    .de(de_a), .line_start(ls_a), .frame_start(fs_a)
`ifdef VGA_TIM_FRAME_CNT_EN
    , .frame_cnt(fc_a)
`endif
  );

  vga_timing_gen #(
    .H_ACTIVE(MODE_B.h_active), .H_FP(MODE_B.h_fp), .H_SYNC(MODE_B.h_sync), .H_BP(MODE_B.h_bp),
    .V_ACTIVE(MODE_B.v_active), .V_FP(MODE_B.v_fp), .V_SYNC(MODE_B.v_sync), .V_BP(MODE_B.v_bp),
    .H_SYNC_POL(MODE_B.h_pol), .V_SYNC_POL(MODE_B.v_pol)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .tim(tim_b),
    .de(de_b), .line_start(ls_b), .frame_start(fs_b)
`ifdef VGA_TIM_FRAME_CNT_EN
    , .frame_cnt(fc_b)
`endif
  );

  vga_timing_gen #(
    .H_ACTIVE(MODE_C.h_active), .H_FP(MODE_C.h_fp), .H_SYNC(MODE_C.h_sync), .H_BP(MODE_C.h_bp),
    .V_ACTIVE(MODE_C.v_active), .V_FP(MODE_C.v_fp), .V_SYNC(MODE_C.v_sync), .V_BP(MODE_C.v_bp),
    .H_SYNC_POL(MODE_C.h_pol), .V_SYNC_POL(MODE_C.v_pol)
  ) dut_c (
    .clk(clk), .rst_n(rst_n), .en(en), .tim(tim_c),
    .de(de_c), .line_start(ls_c), .frame_start(fs_c)
`ifdef VGA_TIM_FRAME_CNT_EN
    , .frame_cnt(fc_c)
`endif
  );

`ifndef VGA_TIM_FRAME_CNT_EN
  assign fc_a = '0;
  assign fc_b = '0;
  assign fc_c = '0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_total = 0;
  int   n_bad   = 0;
  exp_t q_a[$], q_b[$], q_c[$];
  exp_t st_a, st_b, st_c;
  int   hs_cnt_a = 0, hs_lo_b = 0, fs_cnt_c = 0, vs_cnt_c = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, want);
    end
  endtask

  function automatic exp_t reset_exp(input vga_mode_t m);
    exp_t r;
    r    = '0;
    r.hs = ~m.h_pol;
    r.vs = ~m.v_pol;
    r.de = 1'b1;
    return r;
  endfunction

  // Reference: state of the outputs after one clock edge with the given en.
  function automatic exp_t model_next(input vga_mode_t m, input exp_t cur, input logic en_v);
    exp_t n;
    int   ht, vt, hs_lo, vs_lo;
    ht    = int'(m.h_active) + int'(m.h_fp) + int'(m.h_sync) + int'(m.h_bp);
    vt    = int'(m.v_active) + int'(m.v_fp) + int'(m.v_sync) + int'(m.v_bp);
    hs_lo = int'(m.h_active) + int'(m.h_fp);
    vs_lo = int'(m.v_active) + int'(m.v_fp);
    n     = cur;
    n.ls  = 1'b0;
    n.fs  = 1'b0;
    if (en_v) begin
      if (int'(cur.h) == ht - 1) begin
        n.h  = '0;
        n.ls = 1'b1;
        if (int'(cur.v) == vt - 1) begin
          n.v  = '0;
          n.fs = 1'b1;
`ifdef VGA_TIM_FRAME_CNT_EN
          n.fc = cur.fc + 16'd1;
`endif
        end else begin
          n.v = cur.v + 11'd1;
        end
      end else begin
        n.h = cur.h + 11'd1;
      end
      n.hb = (int'(n.h) >= int'(m.h_active));
      n.vb = (int'(n.v) >= int'(m.v_active));
      n.hs = (int'(n.h) >= hs_lo && int'(n.h) < hs_lo + int'(m.h_sync)) ? m.h_pol : ~m.h_pol;
      n.vs = (int'(n.v) >= vs_lo && int'(n.v) < vs_lo + int'(m.v_sync)) ? m.v_pol : ~m.v_pol;
      n.de = ~n.hb & ~n.vb;
    end
    return n;
  endfunction

  function automatic exp_t pack(input logic [10:0] h, input logic [10:0] v, input logic hs,
                                input logic vs, input logic hb, input logic vb, input logic de,
                                input logic ls, input logic fs, input logic [15:0] fc);
    exp_t o;
    o = '{h: h, v: v, hs: hs, vs: vs, hb: hb, vb: vb, de: de, ls: ls, fs: fs, fc: fc};
    return o;
  endfunction

  // Drives one clock edge from the falling-edge+1 point and returns after
  // the following falling edge, when the monitor has compared it.
  task automatic drive(input logic en_v);
    en   = en_v;
    st_a = model_next(MODE_A, st_a, en_v);
    st_b = model_next(MODE_B, st_b, en_v);
    st_c = model_next(MODE_C, st_c, en_v);
    q_a.push_back(st_a);
    q_b.push_back(st_b);
    q_c.push_back(st_c);
    @(negedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (q_a.size() != 0)
      check("sb_a", 64'(pack(tim_a.hcount, tim_a.vcount, tim_a.hsync, tim_a.vsync, tim_a.hblnk,
                             tim_a.vblnk, de_a, ls_a, fs_a, fc_a)), 64'(q_a.pop_front()));
    if (q_b.size() != 0)
      check("sb_b", 64'(pack(tim_b.hcount, tim_b.vcount, tim_b.hsync, tim_b.vsync, tim_b.hblnk,
                             tim_b.vblnk, de_b, ls_b, fs_b, fc_b)), 64'(q_b.pop_front()));
    if (q_c.size() != 0)
      check("sb_c", 64'(pack(tim_c.hcount, tim_c.vcount, tim_c.hsync, tim_c.vsync, tim_c.hblnk,
                             tim_c.vblnk, de_c, ls_c, fs_c, fc_c)), 64'(q_c.pop_front()));
    if (tim_a.hsync)  hs_cnt_a++;
    if (!tim_b.hsync) hs_lo_b++;
    if (fs_c)         fs_cnt_c++;
    if (tim_c.vsync)  vs_cnt_c++;
  end

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    st_a  = reset_exp(MODE_A);
    st_b  = reset_exp(MODE_B);
    st_c  = reset_exp(MODE_C);
    repeat (2) @(negedge clk);
    #1;
    check("rst_hcount",  64'(tim_a.hcount), 64'd0);
    check("rst_de",      64'(de_a),         64'd1);
    check("rst_hsync_a", 64'(tim_a.hsync),  64'd0);
    check("rst_hsync_b", 64'(tim_b.hsync),  64'd1);
    check("rst_vsync_b", 64'(tim_b.vsync),  64'd1);
    rst_n = 1'b1;

    // Run to the last active pixel, then pause for 7 cycles.
    repeat (799) drive(1'b1);
    check("pre_pause_h",  64'(tim_a.hcount), 64'd799);
    check("pre_pause_hb", 64'(tim_a.hblnk),  64'd0);
    repeat (7) begin
      drive(1'b0);
      check("pause_h",       64'(tim_a.hcount), 64'd799);
      check("pause_hb",      64'(tim_a.hblnk),  64'd0);
      check("pause_strobes", 64'({ls_a, fs_a, ls_b, fs_b, ls_c, fs_c}), 64'd0);
    end
    drive(1'b1);
    check("resume_h",  64'(tim_a.hcount), 64'd800);
    check("resume_hb", 64'(tim_a.hblnk),  64'd1);
    check("resume_de", 64'(de_a),         64'd0);

    // Into line 1 at pixel 500 of the 800x600 timing.
    repeat (756) drive(1'b1);
    check("pos_h",         64'(tim_a.hcount), 64'd500);
    check("pos_v",         64'(tim_a.vcount), 64'd1);
    check("hsync_width_a", 64'(hs_cnt_a),     64'd128);
    check("hsync_low_b",   64'(hs_lo_b),      64'd192);

    // Asynchronous reset between clock edges.
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_h",  64'(tim_a.hcount), 64'd0);
    check("arst_v",  64'(tim_a.vcount), 64'd0);
    check("arst_hs", 64'(tim_a.hsync),  64'd0);
    check("arst_de", 64'(de_a),         64'd1);
    check("arst_vs_b", 64'(tim_b.vsync), 64'd1);
    check("arst_fc", 64'(fc_c),         64'd0);
    st_a     = reset_exp(MODE_A);
    st_b     = reset_exp(MODE_B);
    st_c     = reset_exp(MODE_C);
    fs_cnt_c = 0;
    vs_cnt_c = 0;
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;

    drive(1'b1);
    check("rel_h",  64'(tim_a.hcount), 64'd1);
    check("rel_ls", 64'(ls_a),         64'd0);
    check("rel_fs", 64'(fs_c),         64'd0);
    repeat (89) drive(1'b1);
    check("c_last_h", 64'(tim_c.hcount), 64'd12);
    check("c_last_v", 64'(tim_c.vcount), 64'd6);
    check("c_no_fs",  64'(fs_cnt_c),     64'd0);
    drive(1'b1);
    check("c_wrap_v",  64'(tim_c.vcount), 64'd0);
    check("c_wrap_fs", 64'(fs_c),         64'd1);
`ifdef VGA_TIM_FRAME_CNT_EN
    check("c_fc1", 64'(fc_c), 64'd1);
`endif
    repeat (182) drive(1'b1);
    check("c_fs3",     64'(fs_c),     64'd1);
    check("c_fs_cnt",  64'(fs_cnt_c), 64'd3);
    check("c_vs_cnt",  64'(vs_cnt_c), 64'd78);
`ifdef VGA_TIM_FRAME_CNT_EN
    check("c_fc3", 64'(fc_c), 64'd3);
`endif
    check("sb_drain", 64'(q_a.size() + q_b.size() + q_c.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
